// File: rtl/mem_map_pkg.sv
// Address map, switch-register bit layout and lane decode shared by the
// memory controller and its RAM.
package mem_map_pkg;

   localparam int NLANES = 4;

   // Lane addresses are 33 bits so that a vector running past 2^32-1 stays unmapped.
   localparam logic [32:0] SWREG_ADDR    = 33'h3FFF0;
   localparam logic [32:0] GPIODATA_ADDR = 33'h3FFF4;
   localparam logic [32:0] GPIOEN_ADDR   = 33'h3FFF5;

   localparam int SW_INICIO = 0;
   localparam int SW_R0     = 1;
   localparam int SW_G0     = 5;
   localparam int SW_B0     = 9;
   localparam int SW_TD0    = 13;
   localparam int SW_H      = 17;
   localparam int SW_V      = 18;
   localparam int SW_D      = 19;
   localparam int SW_P      = 20;
   localparam int SW_WIDTH  = 21;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_RAM,
      REG_SWREG,
      REG_GPIODATA,
      REG_GPIOEN
   } region_e;

   function automatic region_e decode_region(input logic [32:0] a, input logic [32:0] depth);
      region_e r;
      if (a == SWREG_ADDR)         r = REG_SWREG;
      else if (a == GPIODATA_ADDR) r = REG_GPIODATA;
      else if (a == GPIOEN_ADDR)   r = REG_GPIOEN;
      else if (a < depth)          r = REG_RAM;
      else                         r = REG_NONE;
      return r;
   endfunction

endpackage

// File: rtl/memory_controller_if.sv
// Processor-side bus of the memory controller.
// No valid/ready: the bus is always ready; we=1 at a rising clk commits the
// write, and rd is a purely combinational function of addr, vf and stored state.
interface memory_controller_if;
   logic         we;
   logic         vf;
   logic [127:0] addr;
   logic [127:0] wd;
   logic [127:0] rd;

   modport master (output we, output vf, output addr, output wd, input rd);
   modport slave  (input we, input vf, input addr, input wd, output rd);
endinterface

// File: rtl/memory_controller_data_ram.sv
// Word RAM split into four banks interleaved by address[1:0]; four consecutive
// lane addresses always land in four different banks, so each bank needs one port.
module data_ram
   import mem_map_pkg::*;
#(
   parameter int DEPTH = 131072,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic [NLANES-1:0]            lane_we,
   input  logic [NLANES-1:0][AW-1:0]    lane_addr,
   input  logic [NLANES-1:0][31:0]      lane_wdata,
   output logic [NLANES-1:0][31:0]      lane_rdata
);

   localparam int BANK_DEPTH = DEPTH / 4;

   logic [31:0] bank_rd [4];

   for (genvar b = 0; b < 4; b++) begin : g_bank
      logic [31:0]   mem [BANK_DEPTH];
      logic [AW-3:0] idx;
      logic          wen;
      logic [31:0]   wdat;

      // Route whichever lane currently targets this bank.
      always_comb begin
         idx  = lane_addr[0][AW-1:2];
         wen  = 1'b0;
         wdat = lane_wdata[0];
         for (int k = 0; k < NLANES; k++) begin
            if (lane_addr[k][1:0] == 2'(b)) begin
               idx  = lane_addr[k][AW-1:2];
               wen  = lane_we[k];
               wdat = lane_wdata[k];
            end
         end
      end

      always_ff @(posedge clk) begin
         if (wen) mem[idx] <= wdat;
      end

      assign bank_rd[b] = mem[idx];
   end

   always_comb begin
      for (int k = 0; k < NLANES; k++) lane_rdata[k] = bank_rd[lane_addr[k][1:0]];
   end

endmodule

// File: rtl/memory_controller.sv
// Memory controller: 4-lane scalar/vector access to a word RAM plus a
// synchronized switch register and GPIO data/enable registers.
module memory_controller
   import mem_map_pkg::*;
#(
   parameter int DEPTH = 131072
) (
   input  logic        clk,
   input  logic        rst,
   memory_controller_if.slave bus,
   input  logic        swInicio,
   input  logic        swInR0, swInR25, swInR75, swInR100,
   input  logic        swInG0, swInG25, swInG75, swInG100,
   input  logic        swInB0, swInB25, swInB75, swInB100,
   input  logic        swTD0, swTD25, swTD75, swTD100,
   input  logic        swH, swV, swD, swP,
   output logic [31:0] GPIO,
   output logic        GPIOEnR,
   output logic        GPIOEnG,
   output logic        GPIOEnB
);

   localparam int AW = $clog2(DEPTH);

   logic [NLANES-1:0][31:0] wd_lane;
   logic [NLANES-1:0][31:0] ram_rd;
   logic [NLANES-1:0][31:0] lane_rd;
   logic [NLANES-1:0][AW-1:0] ram_addr;
   logic [NLANES-1:0]       ram_we;
   logic [32:0]             lane_addr [NLANES];
   region_e                 lane_reg [NLANES];

   logic [SW_WIDTH-1:0] sw_raw;
   logic [SW_WIDTH-1:0] sw_sync1;
   logic [SW_WIDTH-1:0] sw_sync2;

   logic unused_addr_hi;
   assign unused_addr_hi = ^bus.addr[127:32];

   assign wd_lane = bus.wd;

   // Inactive lanes decode as REG_NONE, which gates both their writes and reads.
   always_comb begin
      for (int k = 0; k < NLANES; k++) begin
         lane_addr[k] = {1'b0, bus.addr[31:0]} + 33'(k);
         lane_reg[k]  = (bus.vf || k == 0) ? decode_region(lane_addr[k], 33'(DEPTH)) : REG_NONE;
         ram_addr[k]  = lane_addr[k][AW-1:0];
         ram_we[k]    = bus.we && (lane_reg[k] == REG_RAM);
      end
   end

   data_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk        (clk),
      .lane_we    (ram_we),
      .lane_addr  (ram_addr),
      .lane_wdata (wd_lane),
      .lane_rdata (ram_rd)
   );

   always_comb begin
      sw_raw              = '0;
      sw_raw[SW_INICIO]   = swInicio;
      sw_raw[SW_R0+3:SW_R0]   = {swInR100, swInR75, swInR25, swInR0};
      sw_raw[SW_G0+3:SW_G0]   = {swInG100, swInG75, swInG25, swInG0};
      sw_raw[SW_B0+3:SW_B0]   = {swInB100, swInB75, swInB25, swInB0};
      sw_raw[SW_TD0+3:SW_TD0] = {swTD100, swTD75, swTD25, swTD0};
      sw_raw[SW_H]        = swH;
      sw_raw[SW_V]        = swV;
      sw_raw[SW_D]        = swD;
      sw_raw[SW_P]        = swP;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_sync1 <= '0;
         sw_sync2 <= '0;
      end else begin
         sw_sync1 <= sw_raw;
         sw_sync2 <= sw_sync1;
      end
   end

   // Lane addresses are distinct, so at most one lane can hit each register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         GPIO    <= '0;
         GPIOEnR <= 1'b0;
         GPIOEnG <= 1'b0;
         GPIOEnB <= 1'b0;
      end else if (bus.we) begin
         for (int k = 0; k < NLANES; k++) begin
            if (lane_reg[k] == REG_GPIODATA) GPIO <= wd_lane[k];
            if (lane_reg[k] == REG_GPIOEN) {GPIOEnB, GPIOEnG, GPIOEnR} <= wd_lane[k][2:0];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NLANES; k++) begin
         case (lane_reg[k])
            REG_RAM:      lane_rd[k] = ram_rd[k];
            REG_SWREG:    lane_rd[k] = {{(32-SW_WIDTH){1'b0}}, sw_sync2};
            REG_GPIODATA: lane_rd[k] = GPIO;
            REG_GPIOEN:   lane_rd[k] = {29'b0, GPIOEnB, GPIOEnG, GPIOEnR};
            default:      lane_rd[k] = '0;
         endcase
      end
   end

   assign bus.rd = lane_rd;

endmodule

// File: tb/tb_memory_controller.sv
// Randomized scoreboard bench for memory_controller against an address-map
// reference model kept as an associative array plus register variables.
module tb_memory_controller;

  localparam int          DEPTH    = 131072;
  localparam logic [31:0] SWREG    = 32'h3FFF0;
  localparam logic [31:0] GPIODATA = 32'h3FFF4;
  localparam logic [31:0] GPIOEN   = 32'h3FFF5;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  memory_controller_if bus();
  logic [20:0] sw;
  logic [31:0] gpio;
  logic        en_r, en_g, en_b;

  memory_controller #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .swInicio(sw[0]),
    .swInR0(sw[1]),  .swInR25(sw[2]),  .swInR75(sw[3]),  .swInR100(sw[4]),
    .swInG0(sw[5]),  .swInG25(sw[6]),  .swInG75(sw[7]),  .swInG100(sw[8]),
    .swInB0(sw[9]),  .swInB25(sw[10]), .swInB75(sw[11]), .swInB100(sw[12]),
    .swTD0(sw[13]),  .swTD25(sw[14]),  .swTD75(sw[15]),  .swTD100(sw[16]),
    .swH(sw[17]), .swV(sw[18]), .swD(sw[19]), .swP(sw[20]),
    .GPIO(gpio), .GPIOEnR(en_r), .GPIOEnG(en_g), .GPIOEnB(en_b)
  );

  // reference model
  logic [31:0] ram_m [int];
  logic [31:0] gpio_m = '0;
  logic [2:0]  en_m = '0;          // {B, G, R}
  logic [20:0] sw_prev = '0;
  logic [20:0] sw_cur = '0;
  int          sw_set_cyc = 0;
  bit          in_reset = 1'b0;

  function automatic logic [31:0] swreg_m();
    if (in_reset) return 32'h0;
    return (cyc - sw_set_cyc >= 2) ? {11'b0, sw_cur} : {11'b0, sw_prev};
  endfunction

  function automatic logic [31:0] word_m(longint a);
    if (a == longint'(SWREG))    return swreg_m();
    if (a == longint'(GPIODATA)) return gpio_m;
    if (a == longint'(GPIOEN))   return {29'b0, en_m};
    if (a < longint'(DEPTH))     return ram_m.exists(int'(a)) ? ram_m[int'(a)] : 32'h0;
    return 32'h0;
  endfunction

  function automatic logic [127:0] model_rd(logic [31:0] a, bit v);
    logic [127:0] r = '0;
    for (int k = 0; k < 4; k++)
      if (k == 0 || v) r[32*k +: 32] = word_m(longint'(a) + k);
    return r;
  endfunction

  task automatic model_wr(logic [31:0] a, bit v, logic [127:0] d);
    for (int k = 0; k < 4; k++) begin
      longint la = longint'(a) + k;
      if (k == 0 || v) begin
        if (la == longint'(GPIODATA))    gpio_m = d[32*k +: 32];
        else if (la == longint'(GPIOEN)) en_m = d[32*k +: 3];
        else if (la != longint'(SWREG) && la < longint'(DEPTH)) ram_m[int'(la)] = d[32*k +: 32];
      end
    end
  endtask

  // scoreboard
  logic [127:0] exp_q[$];
  int           kind_q[$];
  string        name_q[$];
  bit           chk_req = 1'b0;
  int           checks = 0;
  int           failures = 0;

  always @(negedge clk) begin : monitor
    logic [127:0] e, o;
    int           kd;
    string        nm;
    if (chk_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL monitor: output presented with no expected entry");
      end else begin
        e  = exp_q.pop_front();
        kd = kind_q.pop_front();
        nm = name_q.pop_front();
        o  = (kd == 0) ? bus.rd : {93'b0, gpio, en_b, en_g, en_r};
        if (o !== e) begin
          failures++;
          $display("FAIL %s: got %h expected %h", nm, o, e);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic present(logic [127:0] e, int kd, string nm);
    exp_q.push_back(e);
    kind_q.push_back(kd);
    name_q.push_back(nm);
    chk_req = 1'b1;
    @(negedge clk); #1;
    chk_req = 1'b0;
    tick();
  endtask

  task automatic do_write(logic [31:0] a, bit v, logic [127:0] d);
    bus.we   = 1'b1;
    bus.vf   = v;
    bus.addr = {$urandom, $urandom, $urandom, a};
    bus.wd   = d;
    model_wr(a, v, d);
    tick();
    bus.we = 1'b0;
  endtask

  task automatic expect_rd_val(logic [31:0] a, bit v, logic [127:0] e, string nm);
    bus.we   = 1'b0;
    bus.vf   = v;
    bus.addr = {$urandom, $urandom, $urandom, a};
    present(e, 0, nm);
  endtask

  task automatic expect_rd(logic [31:0] a, bit v, string nm);
    bus.we   = 1'b0;
    bus.vf   = v;
    bus.addr = {$urandom, $urandom, $urandom, a};
    present(model_rd(a, v), 0, nm);
  endtask

  task automatic expect_gpio(string nm);
    present({93'b0, gpio_m, en_m}, 1, nm);
  endtask

  task automatic set_sw(logic [20:0] v);
    sw_prev    = sw_cur;
    sw_cur     = v;
    sw         = v;
    sw_set_cyc = cyc;
  endtask

  task automatic release_reset();
    rst        = 1'b1;
    in_reset   = 1'b0;
    sw_prev    = '0;
    sw_cur     = sw;
    sw_set_cyc = cyc;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0]  a;
    logic [127:0] d;
    bit           v;
    int           sel;
    logic [20:0]  swv;

    bus.we = 1'b0; bus.vf = 1'b0; bus.addr = '0; bus.wd = '0;
    sw = '0;
    #2;
    rst = 1'b0;
    in_reset = 1'b1;
    tick();
    expect_gpio("reset_gpio");
    expect_rd(SWREG, 1'b0, "reset_swreg");
    release_reset();
    tick();
    tick();

    // known contents for every RAM window the random phase reads
    for (int i = 0; i < 5; i++)
      do_write(32'd1000 + 32'(4*i), 1'b1, {$urandom, $urandom, $urandom, $urandom});
    do_write(32'(DEPTH - 8), 1'b1, {$urandom, $urandom, $urandom, $urandom});
    do_write(32'(DEPTH - 4), 1'b1, {$urandom, $urandom, $urandom, $urandom});
    do_write(32'd0, 1'b1, {32'hD0D0_0003, 32'hD0D0_0002, 32'hD0D0_0001, 32'hD0D0_0000});

    // vector write then read, scalar read of lane 2
    do_write(32'd120000, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1});
    expect_rd_val(32'd120000, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1}, "vec_rd");
    expect_rd_val(32'd120002, 1'b0, {96'h0, 32'd3}, "scalar_rd");

    // GPIO registers and asynchronous reset
    do_write(GPIODATA, 1'b0, {96'h0, 32'hA5});
    do_write(GPIOEN, 1'b0, {96'h0, 32'h5});
    present({93'b0, 32'hA5, 3'b101}, 1, "gpio_set");
    expect_rd(GPIOEN, 1'b0, "gpioen_rd");
    expect_rd(GPIODATA, 1'b0, "gpiodata_rd");
    rst = 1'b0;
    in_reset = 1'b1;
    gpio_m = '0;
    en_m = '0;
    present({128'h0}, 1, "gpio_async_rst");
    expect_rd(GPIODATA, 1'b0, "gpiodata_in_rst");
    release_reset();
    expect_gpio("gpio_after_rst");
    tick();
    tick();

    // switch register sees changes exactly two clocks later
    swv = '0;
    swv[0] = 1'b1;
    swv[15] = 1'b1;
    set_sw(swv);
    expect_rd_val(SWREG, 1'b0, 128'h0, "sw_0clk");
    expect_rd_val(SWREG, 1'b0, 128'h0, "sw_1clk");
    expect_rd_val(SWREG, 1'b0, 128'h8001, "sw_2clk");

    // top-of-RAM boundary
    expect_rd(32'(DEPTH - 2), 1'b1, "top_vec_rd");
    do_write(32'(DEPTH - 2), 1'b1, {$urandom, $urandom, $urandom, $urandom});
    expect_rd(32'(DEPTH - 2), 1'b1, "top_vec_rd2");
    expect_rd_val(32'd0, 1'b1, {32'hD0D0_0003, 32'hD0D0_0002, 32'hD0D0_0001, 32'hD0D0_0000}, "ram0_unchanged");

    // randomized mix over RAM, top-of-RAM and MMIO windows
    for (int i = 0; i < 160; i++) begin
      sel = $urandom_range(0, 3);
      v   = 1'($urandom_range(0, 1));
      d   = {$urandom, $urandom, $urandom, $urandom};
      case (sel)
        0:       a = 32'd1000 + 32'($urandom_range(0, 16));
        1:       a = 32'(DEPTH - 6) + 32'($urandom_range(0, 5));
        default: a = 32'h3FFEE + 32'($urandom_range(0, 8));
      endcase
      if (sel == 3 && $urandom_range(0, 1) == 1) begin
        set_sw(21'($urandom_range(0, 32'h1FFFFF)));
        expect_rd(SWREG, 1'b0, "rnd_sw_0");
        expect_rd(SWREG, 1'b0, "rnd_sw_1");
        expect_rd(SWREG, 1'b0, "rnd_sw_2");
      end else begin
        if ($urandom_range(0, 1) == 1) do_write(a, v, d);
        expect_rd(a, v, "rnd_rd");
        if (sel >= 2) expect_gpio("rnd_gpio");
      end
    end

    repeat (3) tick();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
